// File: rtl/serial_rx_if.sv
// serial_rx_if: receive-side word handshake of the serial receiver.
//   data_out   - last received word, LSB first on the line
//   data_valid - data_out holds an unconsumed word
//   data_ready - consumer accepts data_out while data_valid is high
//   frame_err  - one-cycle pulse, stop bit sampled low
//   overrun    - one-cycle pulse, completed word dropped (previous still pending)
// master: the receiver; slave: the consumer.
interface serial_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/serial_rx.sv
// serial_rx: oversampled asynchronous serial receiver (start bit, DATA_W data
// bits LSB first, one stop bit) with a valid/ready word output.
//   clk   - single clock, rising edge
//   rst   - asynchronous active-low reset
//   rx_in - serial line, idle high, asynchronous to clk
//   bus   - serial_rx_if master: data_out/data_valid/data_ready, frame_err, overrun
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | timing to mid start bit, rejects glitches
// DATA      | sampling DATA_W data bits, one per bit period
// STOP      | sampling stop bit, completes or flags frame error
// WAIT_HIGH | after a framing error, wait for the line to return high
module serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_in,
  serial_rx_if.master  bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t            state;
  logic [1:0]        sync;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sync        <= 2'b11;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync        <= {sync[0], rx_in};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumption; a completing frame below may override this.
      if (valid_q && bus.data_ready) valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            // LSB arrives first, so new bits enter at the top and shift down.
            shreg <= (shreg >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
            if (bit_idx == IDX_LAST) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!valid_q || bus.data_ready) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic rx_in = 1'b1;

  serial_rx_if #(.DATA_W(DW)) bus();

  serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  bit pending  = 1'b0;
  logic [7:0] exp_q[$];

  // Monitor: pops the scoreboard whenever a new word is presented.
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic       prev_ovr   = 1'b0;
  logic [7:0] prev_out   = '0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (bus.data_valid && (!prev_valid || prev_hs)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected actual=%02h required=none", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.data_out !== mon_exp) begin
          errors++;
          $display("FAIL word_data actual=%02h required=%02h", bus.data_out, mon_exp);
        end
      end
    end else if (prev_valid && !prev_hs && bus.data_valid) begin
      checks++;
      if (bus.data_out !== prev_out) begin
        errors++;
        $display("FAIL word_held actual=%02h required=%02h", bus.data_out, prev_out);
      end
    end
    if (bus.frame_err) n_ferr++;
    if (bus.overrun)   n_ovr++;
    if (bus.frame_err && prev_ferr) begin
      checks++; errors++;
      $display("FAIL ferr_pulse_width actual=2+ required=1");
    end
    if (bus.overrun && prev_ovr) begin
      checks++; errors++;
      $display("FAIL ovr_pulse_width actual=2+ required=1");
    end
    prev_valid = bus.data_valid;
    prev_hs    = bus.data_valid && bus.data_ready;
    prev_ferr  = bus.frame_err;
    prev_ovr   = bus.overrun;
    prev_out   = bus.data_out;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    tick(CPB);
  endtask

  // Reference model: a good frame is delivered unless a word is still
  // pending with the consumer not ready; a bad stop bit is one frame error.
  task automatic send(input logic [7:0] d, input bit stop_ok);
    logic [7:0] v;
    v = d;
    if (!stop_ok) exp_ferr++;
    else if (pending && !bus.data_ready) exp_ovr++;
    else begin
      exp_q.push_back(v);
      pending = !bus.data_ready;
    end
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(v[i]);
    drive_bit(stop_ok);
  endtask

  task automatic counts(input string tag);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_ovr"}, n_ovr, exp_ovr);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    bus.data_ready = 1'b0;
    #2;
    check("rst_valid", bus.data_valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    tick(3);
    rst = 1'b1;
    tick(3);

    // Single word, consumer not ready: word is held.
    send(8'hA5, 1'b1);
    tick(10);
    check("a5_valid", bus.data_valid, 1);
    check("a5_data", bus.data_out, 8'hA5);
    tick(10);
    check("a5_held", bus.data_valid, 1);
    counts("a5");
    bus.data_ready = 1'b1;
    tick(1);
    pending = 1'b0;
    check("a5_consumed", bus.data_valid, 0);

    // One-clock glitch is rejected.
    rx_in = 1'b0;
    tick(1);
    rx_in = 1'b1;
    tick(12);
    check("glitch_valid", bus.data_valid, 0);
    counts("glitch");
    send(8'h3C, 1'b1);
    tick(10);
    counts("3c");

    // Bad stop bit, line held low: exactly one frame error.
    send(8'h55, 1'b0);
    rx_in = 1'b0;
    tick(20);
    check("ferr_valid", bus.data_valid, 0);
    check("ferr_once", n_ferr, 1);
    rx_in = 1'b1;
    tick(6);
    send(8'h0F, 1'b1);
    tick(10);
    counts("0f");

    // Back-to-back with consumer stalled: second word overruns.
    bus.data_ready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(10);
    check("ovr_valid", bus.data_valid, 1);
    check("ovr_data", bus.data_out, 8'h11);
    counts("ovr");
    bus.data_ready = 1'b1;
    tick(1);
    bus.data_ready = 1'b0;
    pending = 1'b0;
    check("ovr_consumed", bus.data_valid, 0);

    // Consumer always ready.
    bus.data_ready = 1'b1;
    send(8'h81, 1'b1);
    send(8'h7E, 1'b1);
    tick(10);
    check("rdy_valid", bus.data_valid, 0);
    counts("rdy");

    // Reset in the middle of a frame, with a word pending.
    bus.data_ready = 1'b0;
    send(8'h99, 1'b1);
    tick(10);
    check("pre_rst_valid", bus.data_valid, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx_in = 1'b1;
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", bus.data_valid, 0);
    check("mid_rst_data", bus.data_out, 0);
    check("mid_rst_ferr", bus.frame_err, 0);
    check("mid_rst_ovr", bus.overrun, 0);
    pending = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    bus.data_ready = 1'b1;
    send(8'hC3, 1'b1);
    tick(10);
    counts("c3");

    // Randomized frames, good and bad stop bits, random gaps.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit ok;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send(d, ok);
      if (!ok) begin
        rx_in = 1'b0;
        tick($urandom_range(0, 6));
        rx_in = 1'b1;
        tick(2);
      end
      tick($urandom_range(0, 5));
    end
    tick(20);
    counts("rand");
    check("rand_valid", bus.data_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit (even, >= 4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-006 data_out  output  DATA_W  last received word, LSB received first.
REQ-007 data_valid  output  1  data_out holds an unconsumed word.
REQ-008 data_ready  input  1  consumer accepts data_out in any cycle where data_valid=1.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed word dropped because data_valid was still pending.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer; both flops reset to 1; the FSM uses only the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rx_s=0 -> START with the bit counter cleared; otherwise stay in IDLE.
REQ-014 START: at cycle CLKS_PER_BIT/2-1 of the start bit, sample rx_s; 0 -> DATA; 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles after the start mid-point; shift bits in LSB first; after DATA_W samples -> STOP.
REQ-016 STOP: sample CLKS_PER_BIT cycles after the last data sample; 1 -> frame complete, go to IDLE; 0 -> frame_err=1 for one cycle, word discarded, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s=1, then IDLE; a continuously low line SHALL produce exactly one frame_err.
REQ-018 On frame complete with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle: load data_out and set data_valid=1 on the next edge.
REQ-019 On frame complete with data_valid=1 and data_ready=0: keep the old data_out and data_valid, drop the new word, pulse overrun for one cycle.
REQ-020 data_valid=1 and data_ready=1 with no frame completing: clear data_valid on the next edge; data_out keeps its value.
REQ-021 data_out SHALL NOT change while data_valid=1 except under REQ-018.
REQ-022 Latency: data_valid SHALL rise on the clk edge after the stop-bit sample cycle.
REQ-023 The bit-period counter SHALL be sized for CLKS_PER_BIT-1 with no wrap past it; the bit index SHALL be sized for DATA_W.
REQ-024 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-025 rst=0 SHALL immediately force state=IDLE, counters=0, synchronizer=1, data_out=0, data_valid=0, frame_err=0, overrun=0, regardless of clk.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without any output pulse; after reset release, reception SHALL begin at the next falling edge on rx_in.
REQ-027 Release of rst SHALL be assumed synchronous to clk by the surrounding logic; there is no internal reset synchronizer.

Verification (DATA_W=8, CLKS_PER_BIT=4)
REQ-028 Send 0xA5 framed 0/10100101(LSB first)/1 with data_ready=0 -> data_out=0xA5, data_valid=1 and held, frame_err=0, overrun=0.
REQ-029 Drive rx_in low for 1 clk, then high -> no data_valid, no frame_err; a following 0x3C frame is received correctly.
REQ-030 Send 0x55 with the stop bit at 0, then hold the line low for 20 clks -> exactly one frame_err pulse, data_valid stays 0; 0x0F is received after the line returns high.
REQ-031 Send 0x11 then 0x22 back-to-back, data_ready=0 -> data_out=0x11, one overrun pulse; assert data_ready for 1 cycle -> data_valid=0.
REQ-032 Hold data_ready=1 and send 0x81 then 0x7E -> each word is presented once, no overrun, data_valid clears after each word.
REQ-033 Assert rst=0 during bit 3 of 0xFF -> all outputs 0 immediately; after release, 0xC3 is received exactly.
